// File: rtl/sie_ignition_if.sv
`default_nettype none
// ============================================================================
// Module   : sie_ignition_if
// Brief    : Sample input and event/status outputs of the SIE ignition controller.
// Revision : 1.0
// ============================================================================
interface sie_ignition_if #(
  parameter int WIDTH = 18,
  parameter int CNT_W = 16
);
  logic                    clk_en;
  logic signed [WIDTH-1:0] kuramoto_R;
  logic [1:0]              state;
  logic                    ignition_active;
  logic                    ignition_pulse;
  logic                    coupling_mode;
  logic [CNT_W-1:0]        event_count;
  logic signed [WIDTH-1:0] peak_R;
  logic [CNT_W-1:0]        last_duration;
  logic                    timeout_flag;

  modport master (
    output clk_en, kuramoto_R,
    input  state, ignition_active, ignition_pulse, coupling_mode,
           event_count, peak_R, last_duration, timeout_flag
  );

  modport slave (
    input  clk_en, kuramoto_R,
    output state, ignition_active, ignition_pulse, coupling_mode,
           event_count, peak_R, last_duration, timeout_flag
  );
endinterface
`default_nettype wire

// File: rtl/sie_ignition_controller.sv
`default_nettype none
// ============================================================================
// Module   : sie_ignition_controller
// Brief    : SIE ignition detector on Kuramoto R (Q14): hysteresis, dwell,
//            refractory; drives coupling_mode and reports event statistics.
//            Optional forced exit after MAX_DUR samples: SIE_MAX_DURATION_EN.
// Revision : 1.0
// ============================================================================
module sie_ignition_controller #(
  parameter int WIDTH       = 18,
  parameter int FRAC        = 14,
  parameter int ON_TH       = 11469,
  parameter int OFF_TH      = 9830,
  parameter int DWELL_CYC   = 4,
  parameter int REFRACT_CYC = 8,
  parameter int MAX_DUR     = 1000,
  parameter int CNT_W       = 16
) (
  input  logic          clk,
  input  logic          rst,
  sie_ignition_if.slave bus
);

  localparam logic [1:0] c_IDLE       = 2'd0;
  localparam logic [1:0] c_ARMING     = 2'd1;
  localparam logic [1:0] c_IGNITED    = 2'd2;
  localparam logic [1:0] c_REFRACTORY = 2'd3;

  localparam int c_DWELL_W = $clog2(DWELL_CYC + 1);
  localparam int c_REFR_W  = $clog2(REFRACT_CYC + 1);

  localparam logic signed [WIDTH-1:0]  c_ON_TH      = WIDTH'(ON_TH);
  localparam logic signed [WIDTH-1:0]  c_OFF_TH     = WIDTH'(OFF_TH);
  localparam logic [c_DWELL_W-1:0]     c_DWELL_LAST = c_DWELL_W'(DWELL_CYC);
  localparam logic [c_REFR_W-1:0]      c_REFR_LAST  = c_REFR_W'(REFRACT_CYC);

  if (DWELL_CYC < 2 || REFRACT_CYC < 1 || OFF_TH > ON_TH || MAX_DUR < 1 ||
      FRAC >= WIDTH) begin : g_param_error
    $error("sie_ignition_controller: illegal parameter combination");
  end

  logic [1:0]              r_state;
  logic [1:0]              w_state_nxt;
  logic signed [WIDTH-1:0] w_r;
  logic                    w_ge_on;
  logic                    w_lt_off;
  logic                    w_timeout;
  logic [c_DWELL_W-1:0]    r_dwell_cnt;
  logic [c_DWELL_W-1:0]    w_dwell_inc;
  logic [c_REFR_W-1:0]     r_refr_cnt;
  logic [c_REFR_W-1:0]     w_refr_inc;
  logic [CNT_W-1:0]        r_dur_cnt;
  logic [CNT_W-1:0]        w_dur_inc;
  logic [CNT_W-1:0]        r_event_count;
  logic [CNT_W-1:0]        w_event_inc;
  logic [CNT_W-1:0]        r_last_duration;
  logic signed [WIDTH-1:0] r_peak_R;
  logic                    r_timeout_flag;
  logic                    r_ignition_active;
  logic                    r_ignition_pulse;
  logic                    r_coupling_mode;
  logic                    w_active_nxt;
  logic                    w_pulse_nxt;

  assign w_r         = bus.kuramoto_R;
  assign w_ge_on     = (w_r >= c_ON_TH);
  assign w_lt_off    = (w_r < c_OFF_TH);
  assign w_dwell_inc = r_dwell_cnt + c_DWELL_W'(1);
  assign w_refr_inc  = r_refr_cnt + c_REFR_W'(1);
  assign w_dur_inc   = (&r_dur_cnt) ? r_dur_cnt : r_dur_cnt + CNT_W'(1);
  assign w_event_inc = (&r_event_count) ? r_event_count : r_event_count + CNT_W'(1);

`ifdef SIE_MAX_DURATION_EN
  localparam logic [CNT_W-1:0] c_MAX_DUR = CNT_W'(MAX_DUR);
  // A below-release sample on the limit sample is a normal exit, not a timeout.
  assign w_timeout = (r_dur_cnt == c_MAX_DUR) && !w_lt_off;
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state           <= c_IDLE;
      r_ignition_active <= 1'b0;
      r_ignition_pulse  <= 1'b0;
      r_coupling_mode   <= 1'b0;
    end else begin
      r_state           <= w_state_nxt;
      r_ignition_active <= w_active_nxt;
      r_ignition_pulse  <= w_pulse_nxt;
      r_coupling_mode   <= w_active_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (bus.clk_en) begin
      case (r_state)
        c_IDLE: begin
          if (w_ge_on) w_state_nxt = c_ARMING;
        end
        c_ARMING: begin
          if (!w_ge_on)                       w_state_nxt = c_IDLE;
          else if (w_dwell_inc == c_DWELL_LAST) w_state_nxt = c_IGNITED;
        end
        c_IGNITED: begin
          if (w_lt_off || w_timeout) w_state_nxt = c_REFRACTORY;
        end
        c_REFRACTORY: begin
          // Completing refractory only returns to IDLE; arming waits a sample.
          if (w_refr_inc == c_REFR_LAST) w_state_nxt = c_IDLE;
        end
        default: w_state_nxt = c_IDLE;
      endcase
    end
  end

  always_comb begin
    w_active_nxt = (w_state_nxt == c_IGNITED);
    w_pulse_nxt  = (w_state_nxt == c_IGNITED) && (r_state != c_IGNITED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dwell_cnt     <= '0;
      r_refr_cnt      <= '0;
      r_dur_cnt       <= '0;
      r_event_count   <= '0;
      r_last_duration <= '0;
      r_peak_R        <= '0;
      r_timeout_flag  <= 1'b0;
    end else if (bus.clk_en) begin
      case (r_state)
        c_IDLE: begin
          r_dwell_cnt <= w_ge_on ? c_DWELL_W'(1) : '0;
        end
        c_ARMING: begin
          if (!w_ge_on) begin
            r_dwell_cnt <= '0;
          end else if (w_dwell_inc == c_DWELL_LAST) begin
            r_dwell_cnt    <= '0;
            r_event_count  <= w_event_inc;
            r_peak_R       <= w_r;
            r_dur_cnt      <= CNT_W'(1);
            r_timeout_flag <= 1'b0;
          end else begin
            r_dwell_cnt <= w_dwell_inc;
          end
        end
        c_IGNITED: begin
          if (w_lt_off) begin
            r_last_duration <= r_dur_cnt;
            r_refr_cnt      <= '0;
          end else if (w_timeout) begin
            r_last_duration <= r_dur_cnt;
            r_refr_cnt      <= '0;
            r_timeout_flag  <= 1'b1;
          end else begin
            r_dur_cnt <= w_dur_inc;
            if (w_r > r_peak_R) r_peak_R <= w_r;
          end
        end
        c_REFRACTORY: begin
          r_refr_cnt <= (w_refr_inc == c_REFR_LAST) ? '0 : w_refr_inc;
        end
        default: r_dwell_cnt <= '0;
      endcase
    end
  end

  assign bus.state           = r_state;
  assign bus.ignition_active = r_ignition_active;
  assign bus.ignition_pulse  = r_ignition_pulse;
  assign bus.coupling_mode   = r_coupling_mode;
  assign bus.event_count     = r_event_count;
  assign bus.peak_R          = r_peak_R;
  assign bus.last_duration   = r_last_duration;
  assign bus.timeout_flag    = r_timeout_flag;

endmodule
`default_nettype wire
